// File: rtl/overlap_module_acc_pkg.sv
// Shared OBS definitions: result width, beat-count width and FSM states
// used by the overlap recombiner and its accumulating wrapper.
package overlap_module_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } obs_state_e;

    function automatic int res_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int beat_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/overlap_core.sv
// OBS overlap: interleaves four W-bit sub-products into a 2W+1 result.
// Purely combinational so other OBS levels can reuse it unregistered.
module overlap_core
    import overlap_module_acc_pkg::*;
#(
    parameter int W = 17
) (
    input  logic [W-1:0]          b_in1,
    input  logic [W-1:0]          b_in2,
    input  logic [W-1:0]          b_in3,
    input  logic [W-1:0]          b_in4,
    output logic [res_w(W)-1:0]  ov
);

    // Even bits pair b_in1[i] with b_in4 shifted up one position.
    for (genvar i = 0; i <= W; i++) begin : g_even
        if (i == 0) begin : g_lo
            assign ov[0] = b_in1[0];
        end else if (i == W) begin : g_hi
            assign ov[2*W] = b_in4[W-1];
        end else begin : g_mid
            assign ov[2*i] = b_in1[i] ^ b_in4[i-1];
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_odd
        assign ov[2*i+1] = b_in2[i] ^ b_in3[i];
    end

endmodule

// File: rtl/overlap_module_acc.sv
// Handshaked OBS overlap stage with XOR burst accumulation, an optional
// pipeline register and a sticky protocol-error flag.
module overlap_module_acc
    import overlap_module_acc_pkg::*;
#(
    parameter int W         = 17,
    parameter int PIPE      = 0,
    parameter int MAX_BEATS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic [W-1:0]                  b_in1,
    input  logic [W-1:0]                  b_in2,
    input  logic [W-1:0]                  b_in3,
    input  logic [W-1:0]                  b_in4,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [res_w(W)-1:0]          out_data,
    output logic [beat_w(MAX_BEATS)-1:0] out_beats,
    output logic                          err,
    input  logic                          err_clr
);

    localparam int RW = res_w(W);
    localparam int CW = beat_w(MAX_BEATS);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    obs_state_e     state;
    logic [RW-1:0]  acc;
    logic [CW-1:0]  cnt;
    logic [RW-1:0]  ov;

    logic           fsm_ready;
    logic           bv;
    logic           bf;
    logic           bl;
    logic [RW-1:0]  bov;

    logic           take;
    logic           burst_open;
    logic           open_new;
    logic           close;
    logic [RW-1:0]  nxt_acc;
    logic [CW-1:0]  nxt_cnt;

    overlap_core #(.W(W)) u_core (
        .b_in1 (b_in1),
        .b_in2 (b_in2),
        .b_in3 (b_in3),
        .b_in4 (b_in4),
        .ov    (ov)
    );

    assign fsm_ready = !(out_valid && !out_ready);

    if (PIPE != 0) begin : g_pipe
        logic           s_valid;
        logic           s_first;
        logic           s_last;
        logic [RW-1:0]  s_ov;

        // Stage refills whenever it is empty or handing its beat on.
        assign in_ready = !s_valid || fsm_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_valid <= 1'b0;
                s_first <= 1'b0;
                s_last  <= 1'b0;
                s_ov    <= '0;
            end else if (in_ready) begin
                s_valid <= in_valid;
                if (in_valid) begin
                    s_first <= in_first;
                    s_last  <= in_last;
                    s_ov    <= ov;
                end
            end
        end

        assign bv  = s_valid;
        assign bf  = s_first;
        assign bl  = s_last;
        assign bov = s_ov;
    end else begin : g_flow
        assign in_ready = fsm_ready;
        assign bv       = in_valid;
        assign bf       = in_first;
        assign bl       = in_last;
        assign bov      = ov;
    end

    assign take       = bv && fsm_ready;
    assign burst_open = (state == ACC);

    // A beat leaving HOLD is handled as if the FSM were already IDLE.
    always_comb begin
        open_new = !burst_open || bf;
        nxt_acc  = open_new ? bov : (acc ^ bov);
        nxt_cnt  = open_new ? CNT_ONE : (cnt + CNT_ONE);
        close    = bl || (nxt_cnt == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
            err       <= 1'b0;
        end else begin
            if (err_clr) begin
                err <= 1'b0;
            end
            if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
                state     <= IDLE;
            end
            if (take) begin
                if (burst_open && bf) begin
                    err <= 1'b1;
                end
                if (close) begin
                    out_data  <= nxt_acc;
                    out_beats <= nxt_cnt;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                    acc       <= '0;
                    cnt       <= '0;
                    if (!bl) begin
                        err <= 1'b1;
                    end
                end else begin
                    acc   <= nxt_acc;
                    cnt   <= nxt_cnt;
                    state <= ACC;
                end
            end
        end
    end

endmodule

// File: tb/tb_overlap_module_acc.sv
// Bench: PIPE=0/MAX_BEATS=4 and PIPE=1/MAX_BEATS=8 instances checked
// against a burst-level reference model of the overlap accumulator.
module tb_overlap_module_acc;

    localparam int W  = 17;
    localparam int RW = 2 * W + 1;

    typedef struct {
        logic [RW-1:0] d;
        int            n;
        bit            e;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;
    logic          err_clr = 1'b0;
    logic [W-1:0]  b1 = '0;
    logic [W-1:0]  b2 = '0;
    logic [W-1:0]  b3 = '0;
    logic [W-1:0]  b4 = '0;
    int            sel = 0;
    bit            bp_rand = 1'b0;

    logic          iv0, iv1, ir0, ir1, ov0, ov1, or0, or1, e0, e1;
    logic [RW-1:0] d0, d1;
    logic [2:0]    nb0;
    logic [3:0]    nb1;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign or0 = (sel == 0) ? out_ready : 1'b1;
    assign or1 = (sel == 1) ? out_ready : 1'b1;

    overlap_module_acc #(.W(W), .PIPE(0), .MAX_BEATS(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv0), .in_ready(ir0),
        .in_first(in_first), .in_last(in_last),
        .b_in1(b1), .b_in2(b2), .b_in3(b3), .b_in4(b4),
        .out_valid(ov0), .out_ready(or0),
        .out_data(d0), .out_beats(nb0),
        .err(e0), .err_clr(err_clr)
    );

    overlap_module_acc #(.W(W), .PIPE(1), .MAX_BEATS(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1),
        .in_first(in_first), .in_last(in_last),
        .b_in1(b1), .b_in2(b2), .b_in3(b3), .b_in4(b4),
        .out_valid(ov1), .out_ready(or1),
        .out_data(d1), .out_beats(nb1),
        .err(e1), .err_clr(err_clr)
    );

    logic          m_ir, m_ov, m_err;
    logic [RW-1:0] m_d;
    int            m_nb;
    assign m_ir  = (sel == 1) ? ir1 : ir0;
    assign m_ov  = (sel == 1) ? ov1 : ov0;
    assign m_err = (sel == 1) ? e1 : e0;
    assign m_d   = (sel == 1) ? d1 : d0;
    assign m_nb  = (sel == 1) ? int'(nb1) : int'(nb0);

    // Reference model: whole bursts as XOR sums of interleaved words.
    res_t          q[$];
    logic [RW-1:0] m_acc = '0;
    int            m_cnt = 0;
    bit            m_open = 1'b0;
    bit            m_errs = 1'b0;
    int            age = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic logic [RW-1:0] spread(input logic [W-1:0] x);
        logic [RW-1:0] r = '0;
        for (int i = 0; i < W; i++) r[2*i] = x[i];
        return r;
    endfunction

    function automatic logic [RW-1:0] ov_ref(input logic [W-1:0] a, b, c, d);
        return spread(a) ^ (spread(b ^ c) << 1) ^ (spread(d) << 2);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_open = 1'b0;
        m_cnt = 0;
        m_acc = '0;
        m_errs = 1'b0;
        age = 0;
    endtask

    task automatic model_accept(input logic [W-1:0] a, b, c, d, input logic f, l);
        int maxb = (sel == 1) ? 8 : 4;
        res_t r;
        if (!m_open || f) begin
            if (m_open && f) m_errs = 1'b1;
            m_acc = ov_ref(a, b, c, d);
            m_cnt = 1;
        end else begin
            m_acc = m_acc ^ ov_ref(a, b, c, d);
            m_cnt = m_cnt + 1;
        end
        m_open = 1'b1;
        if (l || m_cnt == maxb) begin
            if (!l) m_errs = 1'b1;
            r.d = m_acc;
            r.n = m_cnt;
            r.e = m_errs;
            q.push_back(r);
            m_open = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_ov) begin
                age = 0;
                if (q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    chk("out_data", m_d, q[0].d);
                    chk("out_beats", m_nb, q[0].n);
                    if (out_ready) begin
                        chk("err_at_delivery", m_err, q[0].e);
                        void'(q.pop_front());
                    end
                end
            end else if (q.size() > 0) begin
                age++;
                if (age > 2) begin
                    chk("missing_result", 0, 1);
                    age = 0;
                    void'(q.pop_front());
                end
            end
            if (sel == 0) chk("in_ready", m_ir, !(m_ov && !out_ready));
            if (err_clr) m_errs = 1'b0;
            if (in_valid && m_ir) model_accept(b1, b2, b3, b4, in_first, in_last);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_rand) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [W-1:0] a, b, c, d, input logic f, l);
        int t = 0;
        logic ok = 1'b0;
        in_valid = 1'b1;
        b1 = a; b2 = b; b3 = c; b4 = d;
        in_first = f;
        in_last = l;
        while (!ok && t < 100) begin
            @(negedge clk);
            ok = m_ir;
            t++;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic expect_out(input logic [RW-1:0] d, input int n);
        int t = 0;
        @(negedge clk);
        while (!m_ov && t < 4) begin
            @(negedge clk);
            t++;
        end
        chk("lit_valid", m_ov, 1);
        chk("lit_data", m_d, d);
        chk("lit_beats", m_nb, n);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            tick(1);
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", 0, 1);
        tick(3);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"}, m_ir, 1);
        chk({tag, "_out_valid"}, m_ov, 0);
        chk({tag, "_out_data"}, m_d, 0);
        chk({tag, "_out_beats"}, m_nb, 0);
        chk({tag, "_err"}, m_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        logic f;
        logic [RW-1:0] top_bit;
        top_bit = '0;
        top_bit[RW-1] = 1'b1;

        tick(3);
        reset_checks("rst0");
        rst_n = 1'b1;
        tick(2);

        beat(17'h1, 0, 0, 0, 1, 1);
        expect_out(35'h1, 1);
        beat(0, 0, 0, 17'h10000, 1, 1);
        expect_out(top_bit, 1);
        beat(0, 17'h1FFFF, 17'h1FFFF, 0, 1, 1);
        expect_out(35'h0, 1);

        beat(17'h1, 0, 0, 0, 1, 0);
        beat(17'h2, 0, 0, 0, 0, 0);
        beat(17'h1, 0, 0, 0, 0, 1);
        expect_out(35'h4, 3);
        chk("three_beat_err", m_err, 0);

        out_ready = 1'b0;
        beat(17'h3, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", m_ir, 0);
            chk("stall_valid", m_ov, 1);
            chk("stall_data", m_d, 35'h5);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        beat(17'h5, 0, 0, 0, 1, 1);
        expect_out(35'h11, 1);

        beat(17'h1, 0, 0, 0, 1, 0);
        beat(17'h2, 0, 0, 0, 0, 0);
        beat(17'h4, 0, 0, 0, 0, 0);
        beat(17'h8, 0, 0, 0, 0, 0);
        expect_out(35'h55, 4);
        chk("forced_close_err", m_err, 1);
        beat(17'h10, 0, 0, 0, 0, 0);
        beat(17'h0, 0, 0, 0, 0, 1);
        expect_out(35'h100, 2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr", m_err, 0);
        @(posedge clk);
        #1;

        beat(17'h1, 0, 0, 0, 1, 0);
        beat(17'h2, 0, 0, 0, 1, 1);
        expect_out(35'h4, 1);
        chk("refirst_err", m_err, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        drain();

        sel = 1;
        tick(2);
        beat(17'h1, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("pipe_lat_early", m_ov, 0);
        @(posedge clk);
        #1;
        expect_out(35'h1, 1);

        bp_rand = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            if ($urandom_range(0, 9) == 0) len = $urandom_range(9, 10);
            else len = $urandom_range(1, 8);
            if ($urandom_range(0, 39) == 0) begin
                drain();
                err_clr = 1'b1;
                tick(1);
                err_clr = 1'b0;
            end
            for (int k = 0; k < len; k++) begin
                if (k == 0) f = ($urandom_range(0, 9) != 0);
                else f = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
                beat(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                     f, k == len - 1);
            end
        end
        drain();
        bp_rand = 1'b0;
        tick(1);

        out_ready = 1'b0;
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        beat(17'h1, 0, 0, 0, 1, 0);
        beat(17'h2, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        reset_checks("rst_mid");
        model_reset();
        tick(2);
        @(negedge clk);
        chk("rst_no_out", m_ov, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        beat(17'h1, 0, 0, 0, 1, 1);
        tick(1);
        @(negedge clk);
        chk("hold_valid", m_ov, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        reset_checks("rst_hold");
        model_reset();
        tick(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(1);

        beat(17'h4, 0, 0, 0, 1, 1);
        expect_out(35'h10, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
